// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Purpose:
//   Collects a framed serial bit stream into a WIDTH-bit parallel word. A frame
//   begins with a bit marked by sin_start. The bit order, MSB-first or
//   LSB-first, is latched with that start bit. Idle cycles (sin_valid=0) may
//   appear anywhere inside a frame. A finished word goes into a one-deep output
//   register that has a valid/ready handshake. If that register still holds an
//   unconsumed word, the new word is dropped and the sticky overrun flag is set.
//
// Optional feature (macro PARITY_CHECK_EN):
//   With the macro defined, each frame carries one extra even-parity bit after
//   the data bits. parity_err is then reported alongside dout. With the macro
//   undefined, the parity_err port and the PARITY state do not exist.
//
// Parameters:
//   WIDTH        parallel word width in bits (2..32)
//
// Ports:
//   clock        input   rising-edge clock
//   reset_n      input   asynchronous active-low reset
//   sin          input   serial data bit
//   sin_valid    input   sin is valid this cycle
//   sin_start    input   first bit of a frame (qualified by sin_valid)
//   lsb_first    input   bit order, 1 = LSB first; sampled with the start bit
//   dout         output  assembled parallel word
//   dout_valid   output  dout holds an unconsumed word
//   dout_ready   input   consumer accepts dout
//   overrun      output  sticky: a completed frame was dropped
//   parity_err   output  parity mismatch for the word in dout (PARITY_CHECK_EN)
// -----------------------------------------------------------------------------
module serial_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  // The counter must be able to hold WIDTH, the data-bit count reached before
  // the parity bit.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_lsb;
  logic             w_lsb_nxt;
  logic             w_offer;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
`ifdef PARITY_CHECK_EN
  logic             w_perr;
  logic             r_perr;
`endif

  // MSB-first enters at bit 0 and moves left. LSB-first enters at the top bit
  // and moves right. After WIDTH bits, the first bit received therefore sits at
  // bit WIDTH-1 (MSB-first) or bit 0 (LSB-first).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             b,
                                                input logic             lsb);
    if (lsb) begin
      return {b, cur[WIDTH-1:1]};
    end else begin
      return {cur[WIDTH-2:0], b};
    end
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame-assembly logic
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_lsb_nxt   = r_lsb;
    w_offer     = 1'b0;
    w_word      = r_shift;
`ifdef PARITY_CHECK_EN
    w_perr      = 1'b0;
`endif

    if (sin_valid && sin_start) begin
      // A start bit opens a new frame from any state. Any partial frame is
      // discarded, and the bit order is latched again.
      w_shift_nxt = shift_in('0, sin, lsb_first);
      w_cnt_nxt   = CNT_W'(1);
      w_lsb_nxt   = lsb_first;
      w_state_nxt = SHIFT;
    end else if (sin_valid) begin
      case (r_state)
        SHIFT: begin
          w_shift_nxt = shift_in(r_shift, sin, r_lsb);
          if (r_cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = PARITY;
`else
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
            w_offer     = 1'b1;
            w_word      = w_shift_nxt;
`endif
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          // Even parity: the XOR of the data bits and the parity bit is 0.
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          w_offer     = 1'b1;
          w_word      = r_shift;
          w_perr      = (^r_shift) ^ sin;
        end
`endif
        default: begin
          // IDLE: data bits without a start bit are ignored.
        end
      endcase
    end
  end

  // Frame-assembly registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_lsb   <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lsb   <= w_lsb_nxt;
    end
  end

  // The output register accepts a new word when it is empty, or when its
  // current word is being consumed on this same edge.
  assign w_load = w_offer && (!dout_valid || dout_ready);

  // Output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_perr     <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        dout       <= w_word;
        dout_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        r_perr     <= w_perr;
`endif
      end else if (w_offer) begin
        overrun <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
        r_perr     <= 1'b0;
`endif
      end
    end
  end

`ifdef PARITY_CHECK_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         sin;
  logic         sin_valid;
  logic         sin_start;
  logic         lsb_first;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         overrun;
`ifdef PARITY_CHECK_EN
  logic         parity_err;
`endif

  serial_deserializer #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .lsb_first  (lsb_first),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb_q[$];
  logic         mon_en = 1'b0;

  typedef struct {
    logic         lsb;
    logic [W-1:0] seq;   // seq[W-1] is sent first
    int           gap;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge and are consumed by the
  // next rising edge.
  task automatic drive_bit(input logic b, input logic v, input logic s,
                           input logic l, input logic r);
    @(posedge clock);
    #2;
    sin        = b;
    sin_valid  = v;
    sin_start  = s;
    lsb_first  = l;
    dout_ready = r;
  endtask

  task automatic drive_idle(input logic r);
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, r);
  endtask

  // Drives one whole frame. The final bit is only driven here; the caller's
  // next drive_* call waits for the edge that consumes it.
  task automatic send_frame(input logic l, input logic [W-1:0] seq, input int gap,
                            input logic rb, input logic rl);
`ifdef PARITY_CHECK_EN
    localparam bit HAS_P = 1'b1;
`else
    localparam bit HAS_P = 1'b0;
`endif
    for (int i = W - 1; i >= 0; i--) begin
      bit last;
      last = (i == 0) && !HAS_P;
      drive_bit(seq[i], 1'b1, (i == W - 1), l, last ? rl : rb);
      if (!last) begin
        repeat (gap) drive_idle(rb);
      end
    end
`ifdef PARITY_CHECK_EN
    drive_bit(^seq, 1'b1, 1'b0, l, rl);
`endif
  endtask

  // Scoreboard: pops one expected word for every handshake the DUT makes.
  always @(negedge clock) begin
    if (mon_en && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no word", dout);
      end else begin
        logic [W-1:0] e;
        e = sb_q.pop_front();
        check("sb_dout", 32'(dout), 32'(e));
`ifdef PARITY_CHECK_EN
        check("sb_parity_err", 32'(parity_err), 0);
`endif
      end
    end
  end

  initial begin
    vecs[0] = '{lsb: 1'b0, seq: 4'b1011, gap: 0, exp: 4'b1011};
    vecs[1] = '{lsb: 1'b1, seq: 4'b1100, gap: 0, exp: 4'b0011};
    vecs[2] = '{lsb: 1'b0, seq: 4'b0111, gap: 2, exp: 4'b0111};
    vecs[3] = '{lsb: 1'b1, seq: 4'b1000, gap: 0, exp: 4'b0001};
    vecs[4] = '{lsb: 1'b0, seq: 4'b1000, gap: 1, exp: 4'b1000};
    vecs[5] = '{lsb: 1'b1, seq: 4'b0110, gap: 3, exp: 4'b0110};
    vecs[6] = '{lsb: 1'b0, seq: 4'b0000, gap: 0, exp: 4'b0000};
    vecs[7] = '{lsb: 1'b1, seq: 4'b1101, gap: 1, exp: 4'b1011};

    reset_n    = 1'b0;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    sin_start  = 1'b0;
    lsb_first  = 1'b0;
    dout_ready = 1'b0;

    // Reset values, sampled before the first clock edge
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
`ifdef PARITY_CHECK_EN
    check("rst_parity_err", 32'(parity_err), 0);
`endif
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;

    // MSB-first 1,0,1,1: the word appears on the final bit's edge
    send_frame(1'b0, 4'b1011, 0, 1'b0, 1'b0);
    check("lat_valid_before_last", 32'(dout_valid), 0);
    drive_idle(1'b0);
    check("lat_valid_at_last", 32'(dout_valid), 1);
    check("lat_dout", 32'(dout), 32'(4'b1011));
    check("lat_overrun", 32'(overrun), 0);

    // A second frame while the first is unconsumed is dropped
    send_frame(1'b0, 4'b0101, 0, 1'b0, 1'b0);
    drive_idle(1'b0);
    check("ovr1_dout_hold", 32'(dout), 32'(4'b1011));
    check("ovr1_overrun", 32'(overrun), 1);

    // Reset after 2 of 4 bits clears the outputs with no clock edge
    drive_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_idle(1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout), 0);
    check("arst_dout_valid", 32'(dout_valid), 0);
    check("arst_overrun", 32'(overrun), 0);
    #2;
    reset_n = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) drive_idle(1'b1);
    check("arst_nostart_valid", 32'(dout_valid), 0);
    check("arst_nostart_dout", 32'(dout), 0);

    // 1010 then 0101 with no consumer, then a completion plus handshake
    send_frame(1'b0, 4'b1010, 0, 1'b0, 1'b0);
    drive_idle(1'b0);
    check("ovr2_first", 32'(dout), 32'(4'b1010));
    send_frame(1'b0, 4'b0101, 0, 1'b0, 1'b0);
    drive_idle(1'b0);
    check("ovr2_dout_hold", 32'(dout), 32'(4'b1010));
    check("ovr2_overrun", 32'(overrun), 1);
    send_frame(1'b0, 4'b1100, 0, 1'b0, 1'b1);
    drive_idle(1'b1);
    check("ovr2_load_dout", 32'(dout), 32'(4'b1100));
    check("ovr2_load_valid", 32'(dout_valid), 1);
    check("ovr2_load_overrun", 32'(overrun), 1);
    drive_idle(1'b1);
    check("hs_valid_clear", 32'(dout_valid), 0);
    check("hs_dout_hold", 32'(dout), 32'(4'b1100));
    check("hs_overrun_sticky", 32'(overrun), 1);

    // Restart mid-frame; the new start latches a different bit order
    drive_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(1'b1, 4'b1000, 0, 1'b1, 1'b1);
    drive_idle(1'b1);
    check("restart_dout", 32'(dout), 32'(4'b0001));
    check("restart_valid", 32'(dout_valid), 1);
    drive_idle(1'b1);

`ifdef PARITY_CHECK_EN
    // Data 1,0,1,0 with a wrong parity bit, then with a correct one
    drive_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_idle(1'b1);
    check("par_bad_err", 32'(parity_err), 1);
    check("par_bad_dout", 32'(dout), 32'(4'b1010));
    drive_idle(1'b1);
    check("par_hs_clear", 32'(parity_err), 0);
    drive_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_idle(1'b1);
    check("par_good_err", 32'(parity_err), 0);
    check("par_good_valid", 32'(dout_valid), 1);
    drive_idle(1'b1);
`endif

    // Table-driven frames checked through the scoreboard
    repeat (2) drive_idle(1'b1);
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back(vecs[k].exp);
      send_frame(vecs[k].lsb, vecs[k].seq, vecs[k].gap, 1'b1, 1'b1);
      repeat (2) drive_idle(1'b1);
    end
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) drive_idle(1'b1);
    check("sb_drained", 32'(sb_q.size()), 0);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The module SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The module SHALL have port sin  input  1  serial data bit.
REQ-005 The module SHALL have port sin_valid  input  1  sin is valid this cycle.
REQ-006 The module SHALL have port sin_start  input  1  first bit of a frame; qualified by sin_valid.
REQ-007 The module SHALL have port lsb_first  input  1  bit order, 1 = LSB first, 0 = MSB first; sampled with the start bit.
REQ-008 The module SHALL have port dout  output  WIDTH  assembled parallel word.
REQ-009 The module SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 The module SHALL have port dout_ready  input  1  consumer accepts dout; transfer when dout_valid and dout_ready are both 1.
REQ-011 The module SHALL have port overrun  output  1  sticky, a completed frame was dropped.
REQ-012 The module SHALL have port parity_err  output  1  present only with PARITY_CHECK_EN.

Function
REQ-013 The module SHALL run an FSM with states IDLE and SHIFT, plus PARITY when PARITY_CHECK_EN is defined.
REQ-014 In IDLE, a bit with sin_valid=1 and sin_start=0 SHALL be ignored.
REQ-015 In IDLE, sin_valid=1 with sin_start=1 SHALL accept the bit as bit 0, latch lsb_first, and move to SHIFT.
REQ-016 Each accepted bit SHALL shift in as follows: MSB-first shifts into bit 0 with left shift; LSB-first shifts into bit WIDTH-1 with right shift.
REQ-017 Cycles with sin_valid=0 SHALL leave the shift register and bit counter unchanged, so gaps are allowed.
REQ-018 sin_start=1 with sin_valid=1 in SHIFT or PARITY SHALL discard the partial frame and restart at bit 0.
REQ-019 On the edge accepting the final frame bit, the FSM SHALL return to IDLE and the word SHALL be offered to the output register.
REQ-020 An offered word SHALL load dout and set dout_valid=1 on that same edge if dout_valid=0 or dout_ready=1.
REQ-021 Otherwise the offered word SHALL be dropped, dout SHALL hold its value, and overrun SHALL be set.
REQ-022 A handshake (dout_valid and dout_ready) with no simultaneous completion SHALL clear dout_valid on that edge; dout SHALL hold its value.
REQ-023 overrun SHALL be cleared only by reset.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap past the frame length.

Reset
REQ-025 While reset_n=0, the FSM SHALL be IDLE, and the shift register, counter, dout, dout_valid, overrun and parity_err SHALL be 0, immediately and without a clock.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, the next frame requires sin_start.

Configuration
REQ-027 With macro PARITY_CHECK_EN defined, each frame SHALL carry one extra even-parity bit after the WIDTH data bits, accepted in state PARITY.
REQ-028 With PARITY_CHECK_EN, parity_err SHALL load with dout when XOR(data bits, parity bit)=1, and SHALL clear on handshake when no new word loads.
REQ-029 Without PARITY_CHECK_EN, the parity_err port and PARITY state SHALL not exist, and frames SHALL be exactly WIDTH bits.

Verification (WIDTH=4, macro undefined unless stated)
REQ-030 reset_n pulled low after 2 of 4 bits -> dout=0000 and dout_valid=0 asynchronously; the next 3 bits without start are ignored.
REQ-031 MSB-first bits 1,0,1,1 contiguous, start on the first, dout_ready=1 -> dout=1011 and dout_valid=1 from the 4th bit's edge.
REQ-032 LSB-first bits 1,1,0,0 -> dout=0011.
REQ-033 MSB-first bits 0,1,1,1 with 2 idle cycles between each bit -> dout=0111; dout_valid stays 0 until the 4th bit.
REQ-034 Frame 1010 then frame 0101 with dout_ready=0 -> dout stays 1010, overrun=1; dout_ready=1 completing a frame on the same edge -> new word loads, overrun unchanged.
REQ-035 PARITY_CHECK_EN defined: bits 1,0,1,0 plus parity 1 -> parity_err=1; plus parity 0 -> parity_err=0.
